gateman_gate_gen: RTL and testbench

- Drives the GATE/GATEchgd pair into the envelope generators (NCA/NCF ADSR) from parsed MIDI note events.
- Keeps a last-note-priority note stack and presents the current note and velocity.
- Generates gate edges so the ADSR starts, retriggers and releases correctly.
- Sits between the MIDI note parser and the per-voice ADSR/oscillator blocks.

---
 rtl/gateman_pkg.sv | 31 +++
 rtl/gateman_gate_gen_if.sv | 19 +
 rtl/gateman_gate_gen_note_stack.sv | 93 +++++++++
 rtl/gateman_gate_gen.sv | 162 ++++++++++++++++
 tb/tb_gateman_gate_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/gateman_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gateman_pkg                                                          |
// | Shared widths, FSM encodings and note-stack entry type.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gateman_pkg;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int CNT_W  = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    EV_IDLE = 2'd0,
    EV_SCAN = 2'd1,
    EV_UPD  = 2'd2
  } ev_state_t;

  typedef enum logic [1:0] {
    G_OFF = 2'd0,
    G_ON  = 2'd1,
    G_GAP = 2'd2
  } gate_state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } entry_t;
endpackage
`default_nettype wire

// File: rtl/gateman_gate_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gateman_gate_gen_if                                                  |
// | Note-event valid/ready channel from the MIDI parser.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gateman_gate_gen_if;
  import gateman_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [VEL_W-1:0]  ev_vel;

  modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/gateman_gate_gen_note_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gateman_note_stack                                                   |
// | Held-note stack: one-entry-per-clock match scan, one-clock update.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gateman_note_stack
  import gateman_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start,
  input  logic              scan_en,
  input  logic [NOTE_W-1:0] key,
  input  logic              upd_en,
  input  logic              upd_on,
  input  entry_t            upd_ent,
  input  logic              rem_en,
  input  cnt_t              rem_idx,
  output logic              scan_done,
  output logic              hit,
  output cnt_t              hit_idx,
  output cnt_t              cnt,
  output cnt_t              cnt_new,
  output entry_t            top_new
);
  localparam cnt_t ONE = cnt_t'(1);

  entry_t mem     [STACK_DEPTH];
  entry_t mem_nxt [STACK_DEPTH];
  entry_t cur;
  cnt_t   scan_idx;
  cnt_t   cnt_rem;
  logic   match;

  always_comb begin
    cur = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (cnt_t'(i) == scan_idx) cur = mem[i];
  end

  assign match     = (cnt != '0) && (cur.note == key);
  assign scan_done = scan_en && ((cnt == '0) || match || (scan_idx == cnt - ONE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx <= '0;
      hit      <= 1'b0;
      hit_idx  <= '0;
    end else if (start) begin
      scan_idx <= '0;
      hit      <= 1'b0;
      hit_idx  <= '0;
    end else if (scan_en && !scan_done) begin
      scan_idx <= scan_idx + ONE;
    end else if (scan_en && match) begin
      hit     <= 1'b1;
      hit_idx <= scan_idx;
    end
  end

  // Remove (shift down above rem_idx), then push on the freed top slot.
  always_comb begin
    cnt_rem = rem_en ? cnt - ONE : cnt;
    for (int i = 0; i < STACK_DEPTH; i++)
      mem_nxt[i] = mem[i];
    for (int i = 0; i < STACK_DEPTH - 1; i++)
      if (rem_en && (cnt_t'(i) >= rem_idx)) mem_nxt[i] = mem[i+1];
    if (upd_on)
      for (int i = 0; i < STACK_DEPTH; i++)
        if (cnt_t'(i) == cnt_rem) mem_nxt[i] = upd_ent;
    cnt_new = upd_on ? cnt_rem + ONE : cnt_rem;
    top_new = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (cnt_t'(i) == cnt_new - ONE) top_new = mem_nxt[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (upd_en) begin
      cnt <= cnt_new;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= mem_nxt[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/gateman_gate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gateman_gate_gen                                                     |
// | GATE/GATEchgd generator with last-note-priority stack for the ADSRs. |
// | Option: GATEMAN_RETRIG_EN enables the retrigger gap on note-on.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gateman_gate_gen
  import gateman_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int RETRIG_CYC  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  gateman_gate_gen_if.slave   ev,
  input  logic                panic,
  output logic                GATE,
  output logic                GATEchgd,
  output logic [NOTE_W-1:0]   note_out,
  output logic [VEL_W-1:0]    vel_out,
  output cnt_t                stack_cnt,
  output logic [7:0]          led
);
  localparam int GAP_W = (RETRIG_CYC > 2) ? $clog2(RETRIG_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRIG_CYC - 1);

  logic              rst_meta, rst_n_s;
  ev_state_t         ev_state, ev_nxt;
  gate_state_t       gate_state, gate_st_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              gate_nxt;
  logic              xfer, upd_en, full, rem_en;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [VEL_W-1:0]  ev_vel_q;
  logic              scan_done, hit;
  cnt_t              hit_idx, cnt_new, rem_idx;
  entry_t            top_new;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n_s  <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n_s  <= rst_meta;
    end
  end

  assign ev.ev_ready = (ev_state == EV_IDLE) && (gate_state != G_GAP) && !panic;
  assign xfer        = ev.ev_valid && ev.ev_ready;
  assign upd_en      = (ev_state == EV_UPD);
  assign full        = (stack_cnt == cnt_t'(STACK_DEPTH));
  assign rem_en      = hit || (ev_on_q && full);
  assign rem_idx     = hit ? hit_idx : '0;

  gateman_note_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clock     (clock),
    .reset_n   (rst_n_s),
    .clear     (panic),
    .start     (xfer),
    .scan_en   (ev_state == EV_SCAN),
    .key       (ev_note_q),
    .upd_en    (upd_en),
    .upd_on    (ev_on_q),
    .upd_ent   ({ev_note_q, ev_vel_q}),
    .rem_en    (rem_en),
    .rem_idx   (rem_idx),
    .scan_done (scan_done),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .cnt       (stack_cnt),
    .cnt_new   (cnt_new),
    .top_new   (top_new)
  );

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ev_state   <= EV_IDLE;
      gate_state <= G_OFF;
      gap_cnt    <= '0;
    end else begin
      ev_state   <= ev_nxt;
      gate_state <= gate_st_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

  always_comb begin
    ev_nxt      = ev_state;
    gate_st_nxt = gate_state;
    gate_nxt    = GATE;
    gap_nxt     = gap_cnt;
    case (ev_state)
      EV_IDLE: if (xfer) ev_nxt = EV_SCAN;
      EV_SCAN: if (scan_done) ev_nxt = EV_UPD;
      EV_UPD:  ev_nxt = EV_IDLE;
      default: ev_nxt = EV_IDLE;
    endcase
    case (gate_state)
      G_OFF: if (upd_en && (cnt_new != '0)) begin
        gate_nxt    = 1'b1;
        gate_st_nxt = G_ON;
      end
      G_ON: if (upd_en) begin
        if (cnt_new == '0) begin
          gate_nxt    = 1'b0;
          gate_st_nxt = G_OFF;
        end
`ifdef GATEMAN_RETRIG_EN
        else if (ev_on_q) begin
          gate_nxt    = 1'b0;
          gate_st_nxt = G_GAP;
          gap_nxt     = '0;
        end
`endif
      end
      G_GAP: if (gap_cnt == GAP_LAST) begin
        gate_nxt    = 1'b1;
        gate_st_nxt = G_ON;
      end else begin
        gap_nxt = gap_cnt + GAP_W'(1);
      end
      default: gate_st_nxt = G_OFF;
    endcase
    if (panic) begin
      ev_nxt      = EV_IDLE;
      gate_st_nxt = G_OFF;
      gate_nxt    = 1'b0;
    end
  end

  // A note-off that missed leaves note/velocity untouched.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      GATE      <= 1'b0;
      GATEchgd  <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      note_out  <= '0;
      vel_out   <= '0;
    end else begin
      GATE     <= gate_nxt;
      GATEchgd <= gate_nxt ^ GATE;
      if (xfer) begin
        ev_on_q   <= ev.ev_on;
        ev_note_q <= ev.ev_note;
        ev_vel_q  <= ev.ev_vel;
      end
      if (!panic && upd_en && (ev_on_q || hit) && (cnt_new != '0)) begin
        note_out <= top_new.note;
        vel_out  <= top_new.vel;
      end
    end
  end

  assign led = {1'b0, ev_state, gate_state, GATE, (stack_cnt == '0), full};
endmodule
`default_nettype wire

// File: tb/tb_gateman_gate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gateman_gate_gen                                                  |
// | Directed + random note events against a queue-based stack model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gateman_gate_gen;
  import gateman_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
`ifdef GATEMAN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       panic = 1'b0;
  logic       GATE, GATEchgd;
  logic [6:0] note_out, vel_out;
  logic [4:0] stack_cnt;
  logic [7:0] led;

  gateman_gate_gen_if ev_if ();

  gateman_gate_gen #(.STACK_DEPTH(DEPTH), .RETRIG_CYC(GAP)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ev        (ev_if),
    .panic     (panic),
    .GATE      (GATE),
    .GATEchgd  (GATEchgd),
    .note_out  (note_out),
    .vel_out   (vel_out),
    .stack_cnt (stack_cnt),
    .led       (led)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int q_note[$];
  int q_vel[$];
  int exp_note = 0;
  int exp_vel = 0;
  bit exp_gate = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate"}, 32'(GATE), 0);
    check({tag, "_chgd"}, 32'(GATEchgd), 0);
    check({tag, "_note"}, 32'(note_out), 0);
    check({tag, "_vel"}, 32'(vel_out), 0);
    check({tag, "_cnt"}, 32'(stack_cnt), 0);
    check({tag, "_ready"}, 32'(ev_if.ev_ready), 1);
    check({tag, "_led"}, 32'(led), 32'h02);
  endtask

  // Sends one event, then follows it until the block is ready again.
  task automatic do_event(input bit on, input int note, input int vel, input bit hold);
    int  pos, scan, old_size, exp_low, exp_chg, low, chg, gl, waitc;
    bit  old_gate, retrig, done;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = 7'(note);
    ev_if.ev_vel   = 7'(vel);
    waitc = 0;
    while (ev_if.ev_ready !== 1'b1 && waitc < 100) begin
      @(negedge clock);
      waitc++;
    end
    check("ready_wait", 32'(waitc < 100), 1);
    @(posedge clock);
    #1;
    if (!hold) ev_if.ev_valid = 1'b0;

    pos = -1;
    foreach (q_note[i]) if (pos < 0 && q_note[i] == note) pos = i;
    old_size = q_note.size();
    scan     = (pos >= 0) ? pos + 1 : ((old_size == 0) ? 1 : old_size);
    old_gate = exp_gate;
    retrig   = RETRIG && on && (old_size > 0);
    if (pos >= 0) begin
      q_note.delete(pos);
      q_vel.delete(pos);
    end
    if (on) begin
      if (q_note.size() == DEPTH) begin
        void'(q_note.pop_front());
        void'(q_vel.pop_front());
      end
      q_note.push_back(note);
      q_vel.push_back(vel);
    end
    if (q_note.size() > 0) begin
      exp_note = q_note[q_note.size()-1];
      exp_vel  = q_vel[q_vel.size()-1];
    end
    exp_gate = (q_note.size() > 0);
    exp_low  = scan + 1 + (retrig ? GAP : 0);
    exp_chg  = retrig ? 2 : ((old_gate != exp_gate) ? 1 : 0);

    low = 0; chg = 0; gl = 0; done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (GATEchgd === 1'b1) chg++;
      if (GATE === 1'b0) gl++;
      if (ev_if.ev_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      low++;
    end
    check("busy_done", 32'(done), 1);
    check("ready_low_clocks", low, exp_low);
    check("chgd_pulses", chg, exp_chg);
    if (retrig) check("gap_low_clocks", gl, GAP);
    check("stack_cnt", 32'(stack_cnt), q_note.size());
    check("note_out", 32'(note_out), exp_note);
    check("vel_out", 32'(vel_out), exp_vel);
    check("gate", 32'(GATE), 32'(exp_gate));
  endtask

  initial begin
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;
    ev_if.ev_vel   = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check_reset_outputs("post_reset");

    do_event(1'b1, 60, 100, 1'b0);
    check("on60_note", 32'(note_out), 60);
    check("on60_vel", 32'(vel_out), 100);
    check("on60_cnt", 32'(stack_cnt), 1);
    do_event(1'b0, 60, 0, 1'b0);
    check("off60_gate", 32'(GATE), 0);
    check("off60_note_held", 32'(note_out), 60);

    do_event(1'b1, 60, 80, 1'b0);
    do_event(1'b1, 64, 90, 1'b0);
    check("on64_note", 32'(note_out), 64);
    do_event(1'b0, 64, 0, 1'b0);
    check("off64_note", 32'(note_out), 60);
    check("off64_gate", 32'(GATE), 1);
    do_event(1'b0, 60, 0, 1'b0);

    for (int n = 40; n <= 48; n++) do_event(1'b1, n, n + 10, 1'b0);
    check("full_cnt", 32'(stack_cnt), 8);
    check("full_note", 32'(note_out), 48);
    check("full_led", 32'(led[0]), 1);
    do_event(1'b0, 40, 0, 1'b0);
    check("miss_cnt", 32'(stack_cnt), 8);
    for (int n = 41; n <= 48; n++) do_event(1'b0, n, 0, 1'b0);
    check("drain_gate", 32'(GATE), 0);

    do_event(1'b1, 60, 70, 1'b0);
    do_event(1'b1, 60, 71, 1'b0);
    check("dup_cnt", 32'(stack_cnt), 1);
    do_event(1'b0, 60, 0, 1'b0);
    check("dup_off_gate", 32'(GATE), 0);

    for (int k = 0; k < 12; k++)
      do_event(($urandom_range(0, 99) < 65), 60 + $urandom_range(0, 9), $urandom_range(1, 127), 1'b1);
    ev_if.ev_valid = 1'b0;

    for (int k = 0; k < 40; k++)
      do_event(($urandom_range(0, 99) < 60), 60 + $urandom_range(0, 11), $urandom_range(1, 127), 1'b0);

    while (q_note.size() > 0) do_event(1'b0, q_note[0], 0, 1'b0);
    for (int n = 50; n <= 54; n++) do_event(1'b1, n, 100, 1'b0);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = 7'd99;
    @(posedge clock);
    #1 ev_if.ev_valid = 1'b0;
    repeat (2) @(negedge clock);
    panic = 1'b1;
    @(negedge clock);
    check("panic_cnt", 32'(stack_cnt), 0);
    check("panic_gate", 32'(GATE), 0);
    check("panic_chgd", 32'(GATEchgd), 1);
    check("panic_ready", 32'(ev_if.ev_ready), 0);
    check("panic_led", 32'(led), 32'h02);
    @(negedge clock);
    check("panic_chgd_once", 32'(GATEchgd), 0);
    check("panic_ready_held", 32'(ev_if.ev_ready), 0);
    panic = 1'b0;
    q_note.delete();
    q_vel.delete();
    exp_gate = 1'b0;
    #1;
    check("panic_release_ready", 32'(ev_if.ev_ready), 1);
    do_event(1'b1, 70, 33, 1'b0);
    do_event(1'b0, 70, 0, 1'b0);

    do_event(1'b1, 72, 90, 1'b0);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 7'd75;
    ev_if.ev_vel   = 7'd55;
    @(posedge clock);
    #1 ev_if.ev_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q_note.delete();
    q_vel.delete();
    exp_gate = 1'b0;
    exp_note = 0;
    exp_vel  = 0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    do_event(1'b1, 61, 20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
